// File: rtl/fetch_pkg.sv
// Shared definitions for the two-wide instruction fetch queue.
// Entry layout, default sizing and the PC increment per instruction.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int DEPTH   = 8;

  localparam logic [7:0] PC_STEP = 8'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [7:0]         pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Queue storage: DEPTH entries, two write and two read ports.
// Reads are combinational; data words carry no reset.
module fetch_queue_ram #(
  parameter int W     = 24,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we0,
  input  logic [PTR_W-1:0] i_wa0,
  input  logic [W-1:0]     i_wd0,
  input  logic             i_we1,
  input  logic [PTR_W-1:0] i_wa1,
  input  logic [W-1:0]     i_wd1,
  input  logic [PTR_W-1:0] i_ra0,
  output logic [W-1:0]     o_rd0,
  input  logic [PTR_W-1:0] i_ra1,
  output logic [W-1:0]     o_rd1
);

  logic [W-1:0] r_mem [DEPTH];

  // Write both ports; the two addresses are always distinct.
  always_ff @(posedge i_clk) begin
    if (i_we0) r_mem[i_wa0] <= i_wd0;
    if (i_we1) r_mem[i_wa1] <= i_wd1;
  end

  assign o_rd0 = r_mem[i_ra0];
  assign o_rd1 = r_mem[i_ra1];

endmodule

// File: rtl/fetch_queue.sv
// Two-wide fetch queue between imem and decode.
// Optional same-cycle bypass of empty queue: FETCHQ_BYPASS_EN.
module fetch_queue #(
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter int DEPTH   = fetch_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               res,
  input  logic [7:0]         pc_in,
  output logic [7:0]         imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata0,
  input  logic [INSTR_W-1:0] imem_rdata1,
  input  logic               flush,
  output logic               stall_out,
  output logic               out_valid0,
  output logic               out_valid1,
  output logic [INSTR_W-1:0] out_instr0,
  output logic [INSTR_W-1:0] out_instr1,
  output logic [7:0]         out_pc0,
  output logic [7:0]         out_pc1,
  input  logic [1:0]         deq_cnt
);

  import fetch_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int E_W   = INSTR_W + 8;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_inflight;
  logic [7:0]       r_inflight_pc;

  logic [E_W-1:0]   w_rd0;
  logic [E_W-1:0]   w_rd1;
  logic [E_W-1:0]   w_ret0;
  logic [E_W-1:0]   w_ret1;
  logic [E_W-1:0]   w_slot0;
  logic [E_W-1:0]   w_slot1;
  logic [E_W-1:0]   w_wd0;
  logic [E_W-1:0]   w_wd1;
  logic             w_fill;
  logic             w_byp;
  logic             w_v0;
  logic             w_v1;
  logic [1:0]       w_avail;
  logic [1:0]       w_deq;
  logic [1:0]       w_hadv;
  logic [1:0]       w_nenq;
  logic             w_we0;
  logic             w_we1;
  logic             w_stall;
  logic             w_issue;
  logic [CNT_W:0]   w_need;

  assign imem_addr = pc_in;

  // Returning pair, oldest first, tagged with its PCs.
  assign w_ret0 = {imem_rdata0, r_inflight_pc};
  assign w_ret1 = {imem_rdata1, r_inflight_pc + PC_STEP};
  assign w_fill = r_inflight & ~flush;

  // Occupancy plus pending pair; no credit for dequeue.
  assign w_need  = {1'b0, r_count}
                 + {{(CNT_W-1){1'b0}}, r_inflight, 1'b0};
  assign w_stall = w_need > (CNT_W+1)'(DEPTH - 2);
  assign w_issue = ~w_stall & ~flush;

  // Slot selection, dequeue clamp and enqueue steering.
  always_comb begin
    w_v0    = (r_count != '0);
    w_v1    = (r_count >= CNT_W'(2));
    w_slot0 = w_rd0;
    w_slot1 = w_rd1;
    w_wd0   = w_ret0;
    w_wd1   = w_ret1;
    w_nenq  = w_fill ? 2'd2 : 2'd0;
    w_byp   = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    if ((r_count == '0) && w_fill) begin
      w_byp   = 1'b1;
      w_v0    = 1'b1;
      w_v1    = 1'b1;
      w_slot0 = w_ret0;
      w_slot1 = w_ret1;
    end
`endif
    w_avail = {1'b0, w_v0} + {1'b0, w_v1};
    w_deq   = (deq_cnt > w_avail) ? w_avail : deq_cnt;
`ifdef FETCHQ_BYPASS_EN
    if (w_byp) begin
      w_nenq = 2'd2 - w_deq;
      if (w_deq == 2'd1) w_wd0 = w_ret1;
    end
`endif
    w_hadv = w_byp ? 2'd0 : w_deq;
    w_we0  = (w_nenq != 2'd0);
    w_we1  = (w_nenq == 2'd2);
  end

  // Pointer, count and in-flight bookkeeping.
  always_ff @(posedge clk) begin
    if (res) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= pc_in;
      if (flush) begin
        r_count <= '0;
        r_head  <= r_tail;
      end else begin
        r_head  <= r_head + PTR_W'(w_hadv);
        r_tail  <= r_tail + PTR_W'(w_nenq);
        r_count <= r_count + CNT_W'(w_nenq)
                 - CNT_W'(w_hadv);
      end
    end
  end

  fetch_queue_ram #(
    .W     (E_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .i_clk (clk),
    .i_we0 (w_we0),
    .i_wa0 (r_tail),
    .i_wd0 (w_wd0),
    .i_we1 (w_we1),
    .i_wa1 (r_tail + PTR_W'(1)),
    .i_wd1 (w_wd1),
    .i_ra0 (r_head),
    .o_rd0 (w_rd0),
    .i_ra1 (r_head + PTR_W'(1)),
    .o_rd1 (w_rd1)
  );

  assign stall_out  = w_stall & ~res;
  assign out_valid0 = w_v0 & ~res;
  assign out_valid1 = w_v1 & ~res;
  assign out_instr0 = out_valid0 ? w_slot0[E_W-1:8] : '0;
  assign out_instr1 = out_valid1 ? w_slot1[E_W-1:8] : '0;
  assign out_pc0    = out_valid0 ? w_slot0[7:0] : '0;
  assign out_pc1    = out_valid1 ? w_slot1[7:0] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue against a queue-based model.
// Also covers the FETCHQ_BYPASS_EN build when that macro is set.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int D = 8;

  logic               clk = 1'b0;
  logic               res;
  logic [7:0]         pc_in;
  logic [7:0]         imem_addr;
  logic [INSTR_W-1:0] imem_rdata0;
  logic [INSTR_W-1:0] imem_rdata1;
  logic               flush;
  logic               stall_out;
  logic               out_valid0;
  logic               out_valid1;
  logic [INSTR_W-1:0] out_instr0;
  logic [INSTR_W-1:0] out_instr1;
  logic [7:0]         out_pc0;
  logic [7:0]         out_pc1;
  logic [1:0]         deq_cnt;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk         (clk),
    .res         (res),
    .pc_in       (pc_in),
    .imem_addr   (imem_addr),
    .imem_rdata0 (imem_rdata0),
    .imem_rdata1 (imem_rdata1),
    .flush       (flush),
    .stall_out   (stall_out),
    .out_valid0  (out_valid0),
    .out_valid1  (out_valid1),
    .out_instr0  (out_instr0),
    .out_instr1  (out_instr1),
    .out_pc0     (out_pc0),
    .out_pc1     (out_pc1),
    .deq_cnt     (deq_cnt)
  );

  typedef struct {
    bit         v0;
    bit         v1;
    bit         st;
    fq_entry_t  e0;
    fq_entry_t  e1;
    logic [7:0] ad;
  } exp_t;

  exp_t       sb[$];
  fq_entry_t  mq[$];
  bit         m_inf;
  logic [7:0] m_pc;
  logic [7:0] pc_v;
  logic [7:0] prev_pc;
  int         tests = 0;
  int         fails = 0;
  int         max_cnt = 0;

  function automatic logic [INSTR_W-1:0] mem(input logic [7:0] a);
    return {a ^ 8'hC3, ~a};
  endfunction

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endfunction

  task automatic cycle(input bit r, input bit f,
                       input logic [1:0] d, input logic [7:0] tgt);
    exp_t      e;
    fq_entry_t r0;
    fq_entry_t r1;
    int        n;
    int        av;
    int        dq;
    bit        byp;
    res         = r;
    flush       = f;
    deq_cnt     = d;
    pc_in       = pc_v;
    imem_rdata0 = mem(prev_pc);
    imem_rdata1 = mem(prev_pc + 8'd4);
    e.v0 = 0; e.v1 = 0; e.st = 0;
    e.e0 = '0; e.e1 = '0;
    e.ad = pc_v;
    r0.instr = mem(m_pc);
    r0.pc    = m_pc;
    r1.instr = mem(m_pc + 8'd4);
    r1.pc    = m_pc + 8'd4;
    n   = mq.size();
    byp = 0;
    if (!r) begin
      e.st = (n + 2 * int'(m_inf)) > D - 2;
`ifdef FETCHQ_BYPASS_EN
      byp = (n == 0) && m_inf && !f;
`endif
      if (byp) begin
        e.v0 = 1; e.v1 = 1; e.e0 = r0; e.e1 = r1;
      end else begin
        if (n >= 1) begin e.v0 = 1; e.e0 = mq[0]; end
        if (n >= 2) begin e.v1 = 1; e.e1 = mq[1]; end
      end
    end
    sb.push_back(e);
    if (r) begin
      mq.delete(); m_inf = 0; m_pc = '0;
    end else if (f) begin
      mq.delete(); m_inf = 0;
    end else begin
      av = int'(e.v0) + int'(e.v1);
      dq = (int'(d) > av) ? av : int'(d);
      if (byp) begin
        if (dq == 0) mq.push_back(r0);
        if (dq < 2) mq.push_back(r1);
      end else begin
        repeat (dq) void'(mq.pop_front());
        if (m_inf) begin
          mq.push_back(r0);
          mq.push_back(r1);
        end
      end
      m_inf = !e.st;
      if (!e.st) m_pc = pc_v;
    end
    if (mq.size() > max_cnt) max_cnt = mq.size();
    prev_pc = pc_v;
    pc_v = f ? tgt : (e.st ? pc_v : pc_v + 8'd8);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected response per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("imem_addr", 32'(imem_addr), 32'(e.ad));
      chk("stall_out", 32'(stall_out), 32'(e.st));
      chk("out_valid0", 32'(out_valid0), 32'(e.v0));
      chk("out_valid1", 32'(out_valid1), 32'(e.v1));
      chk("out_instr0", 32'(out_instr0), 32'(e.e0.instr));
      chk("out_pc0", 32'(out_pc0), 32'(e.e0.pc));
      chk("out_instr1", 32'(out_instr1), 32'(e.e1.instr));
      chk("out_pc1", 32'(out_pc1), 32'(e.e1.pc));
    end
  end

  initial begin
    res = 1'b1; flush = 1'b0; deq_cnt = '0; pc_in = '0;
    imem_rdata0 = '0; imem_rdata1 = '0;
    m_inf = 0; m_pc = '0; pc_v = '0; prev_pc = '0;
    @(posedge clk);
    #1;
    repeat (2) cycle(1, 0, 2'd0, 8'h00);
    pc_v = 8'h00;
    repeat (10) cycle(0, 0, 2'd0, 8'h00);
    cycle(0, 1, 2'd0, 8'h20);
    repeat (12) cycle(0, 0, 2'd2, 8'h00);
    cycle(0, 1, 2'd0, 8'hFC);
    repeat (3) cycle(0, 0, 2'd0, 8'h00);
    repeat (3) cycle(0, 0, 2'd1, 8'h00);
    repeat (6) cycle(0, 0, 2'd2, 8'h00);
    cycle(0, 1, 2'd0, 8'h40);
    repeat (2) cycle(0, 0, 2'd0, 8'h00);
    cycle(0, 0, 2'd1, 8'h00);
    cycle(0, 1, 2'd0, 8'h80);
    cycle(0, 0, 2'd2, 8'h00);
    repeat (3000) begin
      cycle(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 9) == 0),
            2'($urandom_range(0, 2)),
            8'($urandom) & 8'hFC);
    end
    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d left, expected 0", sb.size());
    end
    tests++;
    if (max_cnt > D) begin
      fails++;
      $display("FAIL model_cnt: got %0d limit %0d", max_cnt, D);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
